// File: rtl/flood_open.sv
`default_nettype none
// ============================================================================
// Module      : flood_open
// Description : Zero-cascade opener for the minesweeper core. A single open
//               request walks the connected region of zero-valued cells
//               using a LIFO stack and a visited bitmap, and issues one
//               open strobe per uncovered cell towards board_cover.
//               Board and cover state are read through a registered lookup
//               port with one cycle of latency.
// Ports       : clk                 system clock
//               reset               asynchronous, active-low
//               start/start_x/_y    one-cycle open request (dropped while busy)
//               rd_x/rd_y           registered lookup address
//               board_val           board value at lookup (0..8, 5'b11111 mine)
//               cover_val           cover state at lookup (0 covered,
//                                   bit0 opened, bit1 flagged)
//               open/open_x/open_y  one-cycle open strobe and cell
//               busy                flood in progress
//               done                one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module flood_open #(
  parameter int X_SIZE       = 16,
  parameter int Y_SIZE       = 16,
  parameter int X_COORD_BITS = 4,
  parameter int Y_COORD_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [X_COORD_BITS-1:0] start_x,
  input  logic [Y_COORD_BITS-1:0] start_y,
  output logic [X_COORD_BITS-1:0] rd_x,
  output logic [Y_COORD_BITS-1:0] rd_y,
  input  logic [4:0]              board_val,
  input  logic [1:0]              cover_val,
  output logic                    open,
  output logic [X_COORD_BITS-1:0] open_x,
  output logic [Y_COORD_BITS-1:0] open_y,
  output logic                    busy,
  output logic                    done
);

  localparam int C_CELLS = X_SIZE * Y_SIZE;
  localparam int C_IDX_W = X_COORD_BITS + Y_COORD_BITS;
  localparam int C_SP_W  = C_IDX_W + 1;

  localparam logic [X_COORD_BITS:0] C_X_LIMIT = (X_COORD_BITS+1)'(X_SIZE);
  localparam logic [Y_COORD_BITS:0] C_Y_LIMIT = (Y_COORD_BITS+1)'(Y_SIZE);
  localparam logic [C_IDX_W-1:0]    C_X_MUL   = C_IDX_W'(X_SIZE);
  localparam logic [C_IDX_W-1:0]    C_IDX_ONE = C_IDX_W'(1);
  localparam logic [C_SP_W-1:0]     C_SP_ONE  = C_SP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_NEIGH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic [C_SP_W-1:0]     r_sp;
  logic [C_CELLS-1:0]    r_visited;
  logic [2:0]            r_nidx;
  logic [C_IDX_W-1:0]    r_stack [C_CELLS];

  logic                    w_accept;
  logic [1:0]              w_dx;
  logic [1:0]              w_dy;
  logic [X_COORD_BITS:0]   w_nx;
  logic [Y_COORD_BITS:0]   w_ny;
  logic                    w_n_in;
  logic [C_IDX_W-1:0]      w_nidx;
  logic [C_IDX_W-1:0]      w_sidx;
  logic                    w_push_neigh;
  logic                    w_push;
  logic [C_IDX_W-1:0]      w_push_data;
  logic [C_IDX_W-1:0]      w_wr_ptr;
  logic [C_IDX_W-1:0]      w_top_ptr;
  logic [C_IDX_W-1:0]      w_top;

  // A request is only taken in IDLE with busy low; busy stays high for the
  // cycle after DONE, which keeps a request on that cycle from being taken.
  assign w_accept = (r_state == S_IDLE) && start && !busy;

  // Neighbour offsets as 2-bit two's complement (2'b11 = -1).
  always_comb begin
    w_dx = 2'b00;
    w_dy = 2'b00;
    case (r_nidx)
      3'd0:    begin w_dx = 2'b11; w_dy = 2'b11; end
      3'd1:    begin w_dx = 2'b00; w_dy = 2'b11; end
      3'd2:    begin w_dx = 2'b01; w_dy = 2'b11; end
      3'd3:    begin w_dx = 2'b11; w_dy = 2'b00; end
      3'd4:    begin w_dx = 2'b01; w_dy = 2'b00; end
      3'd5:    begin w_dx = 2'b11; w_dy = 2'b01; end
      3'd6:    begin w_dx = 2'b00; w_dy = 2'b01; end
      default: begin w_dx = 2'b01; w_dy = 2'b01; end
    endcase
  end

  // One bit wider than the coordinate: -1 shows up with the top bit set, so
  // the left/top edge never wraps onto the opposite side.
  assign w_nx = {1'b0, rd_x} + {{(X_COORD_BITS-1){w_dx[1]}}, w_dx};
  assign w_ny = {1'b0, rd_y} + {{(Y_COORD_BITS-1){w_dy[1]}}, w_dy};

  assign w_n_in = !w_nx[X_COORD_BITS] && ({1'b0, w_nx[X_COORD_BITS-1:0]} < C_X_LIMIT) &&
                  !w_ny[Y_COORD_BITS] && ({1'b0, w_ny[Y_COORD_BITS-1:0]} < C_Y_LIMIT);

  assign w_nidx = C_IDX_W'(w_ny[Y_COORD_BITS-1:0]) * C_X_MUL + C_IDX_W'(w_nx[X_COORD_BITS-1:0]);
  assign w_sidx = C_IDX_W'(start_y) * C_X_MUL + C_IDX_W'(start_x);

  assign w_push_neigh = (r_state == S_NEIGH) && w_n_in && !r_visited[w_nidx];
  assign w_push       = w_accept || w_push_neigh;
  assign w_push_data  = w_accept ? {start_y, start_x}
                                 : {w_ny[Y_COORD_BITS-1:0], w_nx[X_COORD_BITS-1:0]};
  assign w_wr_ptr     = w_accept ? '0 : r_sp[C_IDX_W-1:0];

  // When the stack holds every cell the pointer's low bits wrap to zero, and
  // subtracting one still lands on the last entry.
  assign w_top_ptr = r_sp[C_IDX_W-1:0] - C_IDX_ONE;
  assign w_top     = r_stack[w_top_ptr];

  // Stack storage carries no reset; only entries below the pointer matter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_sp      <= '0;
      r_visited <= '0;
      r_nidx    <= 3'd0;
      rd_x      <= '0;
      rd_y      <= '0;
      open      <= 1'b0;
      open_x    <= '0;
      open_y    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      open <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          if (w_accept) begin
            r_visited         <= '0;
            r_visited[w_sidx] <= 1'b1;
            r_sp              <= C_SP_ONE;
            busy              <= 1'b1;
            r_state           <= S_POP;
          end
        end

        S_POP: begin
          if (r_sp == '0) begin
            r_state <= S_DONE;
          end else begin
            r_sp    <= r_sp - C_SP_ONE;
            rd_x    <= w_top[X_COORD_BITS-1:0];
            rd_y    <= w_top[C_IDX_W-1:X_COORD_BITS];
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_state <= S_CHECK;
        end

        S_CHECK: begin
          // Opened or flagged cells are skipped. Mines are still opened but
          // never spread the flood since their value is not zero.
          if (cover_val == 2'b00) begin
            open   <= 1'b1;
            open_x <= rd_x;
            open_y <= rd_y;
            if (board_val == 5'd0) begin
              r_nidx  <= 3'd0;
              r_state <= S_NEIGH;
            end else begin
              r_state <= S_POP;
            end
          end else begin
            r_state <= S_POP;
          end
        end

        S_NEIGH: begin
          // Marking on push guarantees each cell enters the stack once, so
          // the stack depth never exceeds the cell count.
          if (w_push_neigh) begin
            r_sp              <= r_sp + C_SP_ONE;
            r_visited[w_nidx] <= 1'b1;
          end
          r_nidx <= r_nidx + 3'd1;
          if (r_nidx == 3'd7) begin
            r_state <= S_POP;
          end
        end

        S_DONE: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flood_open.sv
`default_nettype none
// ============================================================================
// Module      : tb_flood_open
// Description : Self-checking bench for flood_open. Emulates the registered
//               board/cover lookup, predicts the open/done/busy waveform with
//               an algorithm-level flood model, and checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flood_open;

  localparam int N    = 256;
  localparam int MAXT = 4096;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] start_x;
  logic [3:0] start_y;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [4:0] board_val;
  logic [1:0] cover_val;
  logic       open;
  logic [3:0] open_x;
  logic [3:0] open_y;
  logic       busy;
  logic       done;

  flood_open dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_x   (start_x),
    .start_y   (start_y),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .board_val (board_val),
    .cover_val (cover_val),
    .open      (open),
    .open_x    (open_x),
    .open_y    (open_y),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board contents and initial cover state (cell index = y*16 + x).
  int brd  [N];
  int cov0 [N];
  int opened_gen [N];
  int gen;

  // Expected waveform, indexed by cycles after the accepting edge.
  bit exp_open [MAXT];
  int exp_cell [MAXT];
  bit exp_done [MAXT];
  bit exp_busy [MAXT];

  int dxs [8];
  int dys [8];

  int n_pass, n_total;
  int tcur;
  bit chk_en;
  int open_cnt, first_open, done_t, edge_hits;

  // Registered lookup and board_cover emulation.
  always @(posedge clk) begin
    board_val <= 5'(brd[int'(rd_y)*16 + int'(rd_x)]);
    if (cov0[int'(rd_y)*16 + int'(rd_x)] != 0)
      cover_val <= 2'(cov0[int'(rd_y)*16 + int'(rd_x)]);
    else
      cover_val <= (opened_gen[int'(rd_y)*16 + int'(rd_x)] == gen) ? 2'b01 : 2'b00;
    if (open) opened_gen[int'(open_y)*16 + int'(open_x)] <= gen;
  end

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s t=%0d: got %0d, want %0d", name, tcur, got, want);
  endtask

  // Depth-first flood in plain arithmetic; each popped cell costs 3 cycles,
  // 11 if it is a zero that scans its neighbours. Returns the first cycle
  // with busy low.
  function automatic int build_model(int sx, int sy);
    int stk[$];
    bit vis[N];
    int t, c, cx, cy, nx, ny;
    for (int i = 0; i < MAXT; i++) begin
      exp_open[i] = 0; exp_cell[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
    end
    for (int i = 0; i < N; i++) vis[i] = 0;
    stk.push_back(sy*16 + sx);
    vis[sy*16 + sx] = 1;
    t = 1;
    while (1) begin
      if (stk.size() == 0) begin
        exp_done[t+1] = 1;
        for (int k = 0; k <= t+1; k++) exp_busy[k] = 1;
        return t + 2;
      end
      c = stk.pop_back();
      if (cov0[c] != 0) begin
        t += 3;
      end else begin
        exp_open[t+2] = 1;
        exp_cell[t+2] = c;
        if (brd[c] == 0) begin
          cx = c % 16; cy = c / 16;
          for (int i = 0; i < 8; i++) begin
            nx = cx + dxs[i]; ny = cy + dys[i];
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[ny*16+nx]) begin
              vis[ny*16+nx] = 1;
              stk.push_back(ny*16 + nx);
            end
          end
          t += 11;
        end else begin
          t += 3;
        end
      end
    end
    return -1;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (tcur < MAXT) begin
        chk("busy", int'(busy), int'(exp_busy[tcur]));
        chk("open", int'(open), int'(exp_open[tcur]));
        if (exp_open[tcur]) begin
          chk("open_x", int'(open_x), exp_cell[tcur] % 16);
          chk("open_y", int'(open_y), exp_cell[tcur] / 16);
        end
        chk("done", int'(done), int'(exp_done[tcur]));
      end
      if (open) begin
        open_cnt++;
        if (first_open < 0) first_open = tcur;
      end
      if (done) done_t = tcur;
      if (busy && (rd_x == 4'd15 || rd_y == 4'd15)) edge_hits++;
      tcur++;
    end
  end

  function automatic void fill_board(int v);
    for (int i = 0; i < N; i++) begin brd[i] = v; cov0[i] = 0; end
  endfunction

  function automatic void make_random(int mine_pct, int flag_pct);
    bit mine[N];
    int cnt, nx, ny;
    for (int i = 0; i < N; i++) mine[i] = ($urandom_range(0, 99) < mine_pct);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
          nx = x + dxs[i]; ny = y + dys[i];
          if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && mine[ny*16+nx]) cnt++;
        end
        brd[y*16+x]  = mine[y*16+x] ? 31 : cnt;
        cov0[y*16+x] = ($urandom_range(0, 99) < flag_pct) ?
                       (($urandom_range(0, 1) == 1) ? 2 : 1) : 0;
      end
  endfunction

  // Runs one flood; guard_t injects a start at (5,5) during that cycle.
  task automatic run_flood(input int sx, input int sy, input int guard_t, output int tend);
    gen++;
    tend       = build_model(sx, sy);
    open_cnt   = 0;
    first_open = -1;
    done_t     = -1;
    edge_hits  = 0;
    @(negedge clk);
    start = 1'b1; start_x = 4'(sx); start_y = 4'(sy);
    @(posedge clk);
    #1;
    start  = 1'b0;
    tcur   = 0;
    chk_en = 1'b1;
    for (int k = 0; k <= tend + 1; k++) begin
      if (k == guard_t) begin start = 1'b1; start_x = 4'd5; start_y = 4'd5; end
      else start = 1'b0;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    start  = 1'b0;
  endtask

  task automatic single_cell_test(input int guard_t);
    int tend;
    fill_board(1);
    brd[1] = 3;
    run_flood(1, 0, guard_t, tend);
    chk("single_tend", tend, 6);
    chk("single_first_open", first_open, 3);
    chk("single_done_t", done_t, 5);
    chk("single_open_cnt", open_cnt, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int tend;
    dxs = '{-1, 0, 1, -1, 1, -1, 0, 1};
    dys = '{-1, -1, -1, 0, 0, 1, 1, 1};
    n_pass = 0; n_total = 0; tcur = 0; chk_en = 0; gen = 0;
    for (int i = 0; i < N; i++) begin opened_gen[i] = -1; brd[i] = 1; cov0[i] = 0; end
    reset = 1'b0; start = 1'b0; start_x = 4'd0; start_y = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_open", int'(open), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd", int'({rd_y, rd_x}), 0);
    reset = 1'b1;

    // Single numbered cell, with a start dropped while busy in IDLE
    single_cell_test(5);

    // All-zero board from the centre, with a mid-flood start dropped
    fill_board(0);
    run_flood(7, 7, 40, tend);
    chk("zero_open_cnt", open_cnt, 256);
    chk("zero_done_t", done_t, tend - 1);

    // Corner: only the 2x2 block is opened, far edges never looked up
    fill_board(2);
    brd[0] = 0; brd[1] = 1; brd[16] = 1; brd[17] = 1;
    run_flood(0, 0, 2, tend);
    chk("corner_open_cnt", open_cnt, 4);
    chk("corner_edge_hits", edge_hits, 0);

    // Flagged start cell
    fill_board(0);
    cov0[4*16+3] = 2;
    run_flood(3, 4, -1, tend);
    chk("flag_open_cnt", open_cnt, 0);
    chk("flag_done_t", done_t, 5);

    // Reset mid-flood
    fill_board(0);
    gen++;
    @(negedge clk);
    start = 1'b1; start_x = 4'd7; start_y = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_open", int'(open), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rd", int'({rd_y, rd_x}), 0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("postrst_open", int'(open), 0);
      chk("postrst_busy", int'(busy), 0);
    end
    single_cell_test(-1);

    // Randomized boards
    for (int r = 0; r < 6; r++) begin
      make_random(int'($urandom_range(4, 25)), int'($urandom_range(0, 8)));
      run_flood(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 30)), tend);
      chk("rand_done_t", done_t, tend - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flood_open.md
# flood_open

Automatic zero-cascade opener for the minesweeper core. On a single open request it walks the connected region of zero-valued cells with a LIFO stack and issues one `open` pulse per cell to `board_cover`. It sits between the game FSM and `board_cover`, and it reads `board` and `board_cover` through a registered lookup port. The game FSM counts opened cells through `opened_cell` as before.

## Interface
- `x_size`, 16, board width in cells
- `y_size`, 16, board height in cells
- `x_coord_bits`, 4, x coordinate width
- `y_coord_bits`, 4, y coordinate width

- `clk` in 1: system clock (`sys_clk`)
- `reset` in 1: asynchronous, active-low
- `start` in 1: one-cycle open request; ignored while `busy`=1
- `start_x` in `x_coord_bits`: x of the requested cell
- `start_y` in `y_coord_bits`: y of the requested cell
- `rd_x` out `x_coord_bits`: lookup x, registered
- `rd_y` out `y_coord_bits`: lookup y, registered
- `board_val` in 5: board value at `rd_x`/`rd_y` (0–8 count, 5'b11111 mine)
- `cover_val` in 2: cover state; 0 covered, bit0 opened, bit1 flagged
- `open` out 1: one-cycle open strobe to `board_cover`
- `open_x` out `x_coord_bits`: cell to open, valid while `open`=1
- `open_y` out `y_coord_bits`: cell to open, valid while `open`=1
- `busy` out 1: flood in progress
- `done` out 1: one-cycle pulse when the flood completes

## Operation
- Storage: a stack of `x_size*y_size` entries, each `x_coord_bits+y_coord_bits` wide.
- Stack pointer is `x_coord_bits+y_coord_bits+1` bits wide.
- Visited bitmap holds one bit per cell. A cell is marked when pushed, so each cell is pushed at most once and the stack cannot overflow.
- States: IDLE, POP, WAIT, CHECK, NEIGH, DONE.
- IDLE:
  - On `start`: clear the visited bitmap, push (`start_x`,`start_y`), mark it visited, go to POP.
- POP:
  - If the stack is empty, go to DONE.
  - Otherwise pop the top entry into the current cell, drive `rd_x`/`rd_y` with it, go to WAIT.
- WAIT: one idle cycle to cover the 1-cycle read latency.
- CHECK: sample `board_val` and `cover_val`.
  - If `cover_val`≠0 (already opened or flagged): no open, go to POP.
  - Otherwise pulse `open` with the current cell.
  - Then, if `board_val`==0, go to NEIGH with index 0; else go to POP.
  - A mine is still opened; losing is the game FSM's job. A mine never spreads the flood.
- NEIGH: spends 8 cycles, one neighbour per cycle, in this order:
  - (-1,-1), (0,-1), (+1,-1), (-1,0), (+1,0), (-1,+1), (0,+1), (+1,+1).
  - Push the neighbour and mark it visited only if it is in bounds and not yet visited.
  - After index 7, go to POP.
- Bounds: neighbour coordinates are computed one bit wider, as signed values.
  - x<0, x≥`x_size`, y<0 or y≥`y_size` are rejected.
  - There is no modular wrap: the neighbour of x=0 is never x=15.
- DONE: assert `done` for one cycle, go to IDLE.
- `start` during `busy` is dropped, not queued.
- Reset values (async, `reset`=0):
  - state IDLE, stack pointer 0, visited all 0.
  - `open`=0, `done`=0, `busy`=0, `rd_x`=`rd_y`=`open_x`=`open_y`=0.
- Reset mid-flood abandons all pending cells. Opens already issued stay issued; no further `open` follows.

## Timing
- All outputs are registered.
- `start` sampled at edge E0: `busy`=1 after E0.
- `rd_x`/`rd_y` update at E1; values are sampled at E3.
- First `open` is high between E3 and E4.
- Per cell:
  - Non-zero or skipped cell: 3 cycles (POP, WAIT, CHECK).
  - Zero-valued cell: 11 cycles (adds 8 NEIGH).
- Single non-zero cell: POP with an empty stack at E4; `done` high E5–E6; `busy` low after E6.
- `open` is never high on two consecutive cycles. Because `board_cover` updates on the edge ending `open`, a later CHECK of the same cell sees it as opened.
- `busy` stays 1 in every state except IDLE, including the DONE cycle.

## Test plan
- Reset: hold `reset`=0 mid-run, then release → `busy`=0, `open`=0, `done`=0, `rd_x`=`rd_y`=0; the next `start` behaves as from cold.
- Single numbered cell: `board_val`=3 at (1,0), start (1,0) → exactly one `open` at (1,0) between E3 and E4, `done` between E5 and E6, no other opens.
- All-zero 16×16 board, start at (7,7) → exactly 256 `open` pulses, each cell opened once, then one `done`; `busy` drops.
- Corner (0,0)=0, neighbours (1,0), (0,1), (1,1)=1, start (0,0) → opens only those 4 cells; no access to x=15 or y=15.
- Flagged or opened start: `cover_val`=2'b10 at the start cell → zero `open` pulses, `done` between E5 and E6.
- Busy guard: a second `start` at (5,5) during an active flood → ignored; only the original flood's cells are opened.
